// File: rtl/fft_ctrl.sv
// fft_ctrl: sequences stages and butterflies of an in-place radix-2 DIT FFT over a ping-pong sample RAM.
// Latency: done pulses 1 + LOG_N*(N/2+BFLY_LAT) cycles after start is sampled; wr_* trail rd_* by BFLY_LAT.
// Backpressure: none; free-running once started, start ignored until back in IDLE.
// Optional build macro FFT_CTRL_INVERSE_EN adds inverse/tw_conj for IFFT twiddle conjugation.
module fft_ctrl #(
   parameter int LOG_N    = 9,
   parameter int BFLY_LAT = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
`ifdef FFT_CTRL_INVERSE_EN
   input  logic               inverse,
   output logic               tw_conj,
`endif
   output logic               busy,
   output logic               done,
   output logic [LOG_N-1:0]   stage,
   output logic               rd_en,
   output logic [LOG_N-1:0]   rd_addr_a,
   output logic [LOG_N-1:0]   rd_addr_b,
   output logic [LOG_N-2:0]   tw_addr,
   output logic               rd_bank,
   output logic               wr_en,
   output logic [LOG_N-1:0]   wr_addr_a,
   output logic [LOG_N-1:0]   wr_addr_b,
   output logic               wr_bank
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;

   localparam logic [LOG_N-1:0] S_ONE   = LOG_N'(1);
   localparam logic [LOG_N-1:0] S_LAST  = LOG_N'(LOG_N - 1);
   localparam logic [LOG_N-2:0] I_ONE   = (LOG_N-1)'(1);
   localparam logic [3:0]       FC_LAST = 4'(BFLY_LAT - 1);

   state_t             state_q, state_d;
   logic [LOG_N-1:0]   s_q, s_d;      // current stage
   logic [LOG_N-2:0]   i_q, i_d;      // butterfly index within stage
   logic [3:0]         fc_q, fc_d;    // flush cycle counter

   logic [LOG_N-1:0]   i_ext, low_mask, lo, addr_a, addr_b, tw_sh;
   logic               rd_active;

   // State and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         i_q     <= '0;
         fc_q    <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         i_q     <= i_d;
         fc_q    <= fc_d;
      end
   end

   // Next-state: N/2 read cycles per stage, then BFLY_LAT flush cycles so the
   // stage's last write lands before the next stage's first read.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      i_d     = i_q;
      fc_d    = fc_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               s_d     = '0;
               i_d     = '0;
            end
         end
         ST_RUN: begin
            i_d = i_q + I_ONE;
            if (&i_q) begin
               state_d = ST_FLUSH;
               fc_d    = '0;
            end
         end
         ST_FLUSH: begin
            fc_d = fc_q + 4'd1;
            if (fc_q == FC_LAST) begin
               if (s_q == S_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
                  s_d     = s_q + S_ONE;
                  i_d     = '0;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            s_d     = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Read-side addressing: A has a 0 inserted at bit s, B sets that bit;
   // twiddle index is the low s bits scaled up to the full ROM range.
   always_comb begin
      rd_active = (state_q == ST_RUN);
      i_ext     = {1'b0, i_q};
      low_mask  = (S_ONE << s_q) - S_ONE;
      lo        = i_ext & low_mask;
      addr_a    = ((i_ext & ~low_mask) << 1) | lo;
      addr_b    = addr_a | (S_ONE << s_q);
      tw_sh     = S_LAST - s_q;
      rd_en     = rd_active;
      rd_addr_a = rd_active ? addr_a : '0;
      rd_addr_b = rd_active ? addr_b : '0;
      tw_addr   = rd_active ? (LOG_N-1)'(lo << tw_sh) : '0;
      rd_bank   = rd_active & s_q[0];
      busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
      done      = (state_q == ST_DONE);
      stage     = s_q;
   end

   logic               dl_vld  [BFLY_LAT];
   logic [LOG_N-1:0]   dl_a    [BFLY_LAT];
   logic [LOG_N-1:0]   dl_b    [BFLY_LAT];
   logic               dl_bank [BFLY_LAT];

   // Write-side delay line: replays each read BFLY_LAT cycles later into the opposite bank
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < BFLY_LAT; k++) begin
            dl_vld[k]  <= 1'b0;
            dl_a[k]    <= '0;
            dl_b[k]    <= '0;
            dl_bank[k] <= 1'b0;
         end
      end else begin
         dl_vld[0]  <= rd_en;
         dl_a[0]    <= rd_addr_a;
         dl_b[0]    <= rd_addr_b;
         dl_bank[0] <= rd_en & ~rd_bank;
         for (int k = 1; k < BFLY_LAT; k++) begin
            dl_vld[k]  <= dl_vld[k-1];
            dl_a[k]    <= dl_a[k-1];
            dl_b[k]    <= dl_b[k-1];
            dl_bank[k] <= dl_bank[k-1];
         end
      end
   end

   assign wr_en     = dl_vld[BFLY_LAT-1];
   assign wr_addr_a = dl_a[BFLY_LAT-1];
   assign wr_addr_b = dl_b[BFLY_LAT-1];
   assign wr_bank   = dl_bank[BFLY_LAT-1];

`ifdef FFT_CTRL_INVERSE_EN
   logic inv_q;

   // Capture transform direction when a run is accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         inv_q <= 1'b0;
      end else if ((state_q == ST_IDLE) && start) begin
         inv_q <= inverse;
      end
   end

   assign tw_conj = busy & inv_q;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
`timescale 1ns/1ps
module tb_fft_ctrl;
   localparam int LOGN = 3;
   localparam int NN   = 8;
   localparam int NI   = 3;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic [2:0] stage;
      logic       rd_en;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [1:0] tw;
      logic       rd_bank;
   } rd_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic       reset_v   [NI];
   logic       start_v   [NI];
   logic       busy_v    [NI];
   logic       done_v    [NI];
   logic [2:0] stage_v   [NI];
   logic       rd_en_v   [NI];
   logic [2:0] ra_v      [NI];
   logic [2:0] rb_v      [NI];
   logic [1:0] tw_v      [NI];
   logic       rd_bank_v [NI];
   logic       wr_en_v   [NI];
   logic [2:0] wa_v      [NI];
   logic [2:0] wb_v      [NI];
   logic       wr_bank_v [NI];
`ifdef FFT_CTRL_INVERSE_EN
   logic       inverse_v [NI];
   logic       tw_conj_v [NI];
`endif

   // Three instances: BFLY_LAT = 2, 1, 5
   for (genvar g = 0; g < NI; g++) begin : g_dut
      fft_ctrl #(.LOG_N(LOGN), .BFLY_LAT(g == 0 ? 2 : (g == 1 ? 1 : 5))) u_dut (
         .clk       (clk),
         .reset     (reset_v[g]),
         .start     (start_v[g]),
`ifdef FFT_CTRL_INVERSE_EN
         .inverse   (inverse_v[g]),
         .tw_conj   (tw_conj_v[g]),
`endif
         .busy      (busy_v[g]),
         .done      (done_v[g]),
         .stage     (stage_v[g]),
         .rd_en     (rd_en_v[g]),
         .rd_addr_a (ra_v[g]),
         .rd_addr_b (rb_v[g]),
         .tw_addr   (tw_v[g]),
         .rd_bank   (rd_bank_v[g]),
         .wr_en     (wr_en_v[g]),
         .wr_addr_a (wa_v[g]),
         .wr_addr_b (wb_v[g]),
         .wr_bank   (wr_bank_v[g])
      );
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
   endfunction

   task automatic test_reset();
      for (int k = 0; k < NI; k++) begin
         reset_v[k] = 1'b1;
         start_v[k] = 1'b0;
`ifdef FFT_CTRL_INVERSE_EN
         inverse_v[k] = 1'b0;
`endif
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         logic [25:0] all_out;
         all_out = {busy_v[k], done_v[k], stage_v[k], rd_en_v[k], ra_v[k], rb_v[k], tw_v[k],
                    rd_bank_v[k], wr_en_v[k], wa_v[k], wb_v[k], wr_bank_v[k]};
         checks++;
         if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs inst=%0d got=%h exp=0", k, all_out);
         end
`ifdef FFT_CTRL_INVERSE_EN
         checks++;
         if (tw_conj_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_tw_conj inst=%0d got=%b exp=0", k, tw_conj_v[k]);
         end
`endif
         reset_v[k] = 1'b0;
      end
      @(negedge clk);
   endtask

   // Full run on instance k, checked cycle by cycle against a model built from
   // the butterfly pairing rules; start is re-pulsed randomly while busy.
   task automatic run_and_check(input int k, input string tag);
      rd_t  exp_q[$];
      rd_t  rec, obs, wexp;
      int   lat, total, last_wr0, first_rd1, done_at;
      logic inv, last_wbank;
      lat = lat_of(k);
      for (int s = 0; s < LOGN; s++) begin
         for (int a = 0; a < NN; a++) begin
            if (((a >> s) & 1) == 0) begin
               rec         = '0;
               rec.busy    = 1'b1;
               rec.stage   = 3'(s);
               rec.rd_en   = 1'b1;
               rec.ra      = 3'(a);
               rec.rb      = 3'(a + (1 << s));
               rec.tw      = 2'((a % (1 << s)) << (LOGN - 1 - s));
               rec.rd_bank = 1'(s % 2);
               exp_q.push_back(rec);
            end
         end
         for (int f = 0; f < lat; f++) begin
            rec       = '0;
            rec.busy  = 1'b1;
            rec.stage = 3'(s);
            exp_q.push_back(rec);
         end
      end
      rec      = '0;
      rec.done = 1'b1;
      exp_q.push_back(rec);
      total = exp_q.size();

      last_wr0 = -1; first_rd1 = -1; done_at = -1; last_wbank = 1'b0;
      inv = 1'($urandom_range(0, 1));
      start_v[k] = 1'b1;
`ifdef FFT_CTRL_INVERSE_EN
      inverse_v[k] = inv;
`endif
      for (int c = 1; c <= total + 2; c++) begin
         @(negedge clk);
         rec  = (c <= total) ? exp_q[c-1] : '0;
         obs  = {busy_v[k], done_v[k], stage_v[k], rd_en_v[k], ra_v[k], rb_v[k], tw_v[k], rd_bank_v[k]};
         if (!rec.busy) obs.stage = rec.stage;
         checks++;
         if (obs !== rec) begin
            errors++;
            $display("FAIL %s rd_side inst=%0d cyc=%0d got=%h exp=%h", tag, k, c, obs, rec);
         end
         wexp = (c - lat >= 1 && c - lat <= total) ? exp_q[c-lat-1] : '0;
         checks++;
         if (wexp.rd_en) begin
            if ({wr_en_v[k], wa_v[k], wb_v[k], wr_bank_v[k]} !== {1'b1, wexp.ra, wexp.rb, ~wexp.rd_bank}) begin
               errors++;
               $display("FAIL %s wr_side inst=%0d cyc=%0d got=%b_%0d_%0d_%b exp=1_%0d_%0d_%b", tag, k, c,
                        wr_en_v[k], wa_v[k], wb_v[k], wr_bank_v[k], wexp.ra, wexp.rb, ~wexp.rd_bank);
            end
         end else if (wr_en_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s wr_idle inst=%0d cyc=%0d got wr_en=%b exp=0", tag, k, c, wr_en_v[k]);
         end
`ifdef FFT_CTRL_INVERSE_EN
         checks++;
         if (tw_conj_v[k] !== (inv & rec.busy)) begin
            errors++;
            $display("FAIL %s tw_conj inst=%0d cyc=%0d got=%b exp=%b", tag, k, c, tw_conj_v[k], inv & rec.busy);
         end
         inverse_v[k] = 1'($urandom_range(0, 1));
`endif
         if (wr_en_v[k] === 1'b1 && wexp.rd_en && wexp.stage == 3'd0) last_wr0 = c;
         if (wr_en_v[k] === 1'b1) last_wbank = wr_bank_v[k];
         if (rd_en_v[k] === 1'b1 && stage_v[k] == 3'd1 && first_rd1 < 0) first_rd1 = c;
         if (done_v[k] === 1'b1 && done_at < 0) done_at = c;
         start_v[k] = (c <= total) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      checks++;
      if (done_at != 1 + LOGN * (NN/2 + lat)) begin
         errors++;
         $display("FAIL %s done_timing inst=%0d got=%0d exp=%0d", tag, k, done_at, 1 + LOGN * (NN/2 + lat));
      end
      checks++;
      if (first_rd1 - last_wr0 != 1) begin
         errors++;
         $display("FAIL %s hazard_gap inst=%0d got=%0d exp=1", tag, k, first_rd1 - last_wr0);
      end
      checks++;
      if (last_wbank !== 1'(LOGN & 1)) begin
         errors++;
         $display("FAIL %s final_bank inst=%0d got=%b exp=%b", tag, k, last_wbank, 1'(LOGN & 1));
      end
      start_v[k] = 1'b0;
   endtask

   task automatic test_fft();
      run_and_check(0, "fft_lat2_a");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_and_check(0, "fft_lat2_b");
   endtask

   task automatic test_latency_sweep();
      run_and_check(1, "sweep_lat1");
      run_and_check(2, "sweep_lat5");
   endtask

   task automatic test_reset_mid_run();
      int wr_seen;
      logic [25:0] all_out;
      start_v[0] = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start_v[0] = 1'b0;
      end
      // stage 1, second butterfly: pair (1,3)
      checks++;
      if ({stage_v[0], rd_en_v[0], ra_v[0], rb_v[0]} !== {3'd1, 1'b1, 3'd1, 3'd3}) begin
         errors++;
         $display("FAIL midrun_position got=%0d_%b_%0d_%0d exp=1_1_1_3", stage_v[0], rd_en_v[0], ra_v[0], rb_v[0]);
      end
      reset_v[0] = 1'b1;
      @(negedge clk);
      reset_v[0] = 1'b0;
      all_out = {busy_v[0], done_v[0], stage_v[0], rd_en_v[0], ra_v[0], rb_v[0], tw_v[0],
                 rd_bank_v[0], wr_en_v[0], wa_v[0], wb_v[0], wr_bank_v[0]};
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL midrun_reset_outputs got=%h exp=0", all_out);
      end
      wr_seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (wr_en_v[0] !== 1'b0 || busy_v[0] !== 1'b0) wr_seen++;
      end
      checks++;
      if (wr_seen != 0) begin
         errors++;
         $display("FAIL midrun_no_write got=%0d exp=0", wr_seen);
      end
      run_and_check(0, "after_reset");
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         reset_v[k] = 1'b1;
         start_v[k] = 1'b0;
`ifdef FFT_CTRL_INVERSE_EN
         inverse_v[k] = 1'b0;
`endif
      end
      test_reset();
      test_fft();
      test_latency_sweep();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
